// File: rtl/mmc1_mapper.sv
// MMC1-class NES cartridge mapper: serial-loaded PRG/CHR/mirroring registers and address mapping.
// Optional PRG-RAM chip enable is built when MMC1_PRG_RAM_EN is defined.
module mmc1_mapper #(
  parameter int unsigned PRG_ADDR_W  = 18,
  parameter int unsigned CHR_ADDR_W  = 17,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  M2,
  input  logic [14:0]           CPU_ADDR,
  input  logic [7:0]            CPU_DATA_IN,
  input  logic                  CPU_RW,
  input  logic                  ROM_CE,
  input  logic [13:0]           PPU_ADDR,
  output logic [PRG_ADDR_W-1:0] PRG_ADDR,
  output logic [CHR_ADDR_W-1:0] CHR_ADDR,
  output logic                  CIRAM_A10,
  output logic                  CIRAM_CE,
  output logic                  PRG_RAM_CE
);

  localparam int unsigned PB = PRG_ADDR_W - 14;
  localparam int unsigned CB = CHR_ADDR_W - 12;

  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
  localparam logic [4:0] CTRL_RESET  = 5'h0C;

  logic [SYNC_STAGES-1:0] m2_sync_q, m2_sync_d;
  logic                   m2_prev_q, m2_prev_d;
  logic [1:0]             snap_sel_q, snap_sel_d;
  logic                   snap_d7_q, snap_d7_d;
  logic                   snap_d0_q, snap_d0_d;
  logic                   snap_rw_q, snap_rw_d;
  logic                   snap_rom_ce_q, snap_rom_ce_d;
  logic [4:0]             shift_q, shift_d;
  logic [4:0]             ctrl_q, ctrl_d;
  logic [4:0]             chr0_q, chr0_d;
  logic [4:0]             chr1_q, chr1_d;
  logic [4:0]             prg_q, prg_d;
  logic                   wr_last_q, wr_last_d;

  logic       m2_s_c;
  logic       eval_c;
  logic       write_c;
  logic [4:0] shift_next_c;
  logic [4:0] prg_bank_c;
  logic [4:0] chr_bank_c;
  logic       unused_c;

  assign m2_s_c = m2_sync_q[SYNC_STAGES-1];

  // Bus capture, write filter and serial register load
  always_comb begin
    m2_sync_d     = {m2_sync_q[SYNC_STAGES-2:0], M2};
    m2_prev_d     = m2_s_c;
    snap_sel_d    = snap_sel_q;
    snap_d7_d     = snap_d7_q;
    snap_d0_d     = snap_d0_q;
    snap_rw_d     = snap_rw_q;
    snap_rom_ce_d = snap_rom_ce_q;
    shift_d       = shift_q;
    ctrl_d        = ctrl_q;
    chr0_d        = chr0_q;
    chr1_d        = chr1_q;
    prg_d         = prg_q;
    wr_last_d     = wr_last_q;

    eval_c       = m2_prev_q & ~m2_s_c;
    write_c      = eval_c & ~snap_rw_q & ~snap_rom_ce_q;
    shift_next_c = {snap_d0_q, shift_q[4:1]};

    if (m2_s_c) begin
      snap_sel_d    = CPU_ADDR[14:13];
      snap_d7_d     = CPU_DATA_IN[7];
      snap_d0_d     = CPU_DATA_IN[0];
      snap_rw_d     = CPU_RW;
      snap_rom_ce_d = ROM_CE;
    end

    if (eval_c) begin
      wr_last_d = write_c;
    end

    // Second write of a read-modify-write pair is dropped
    if (write_c && !wr_last_q) begin
      if (snap_d7_q) begin
        shift_d = SHIFT_EMPTY;
        ctrl_d  = ctrl_q | CTRL_RESET;
      end else if (shift_q[0]) begin
        shift_d = SHIFT_EMPTY;
        unique case (snap_sel_q)
          2'd0:    ctrl_d = shift_next_c;
          2'd1:    chr0_d = shift_next_c;
          2'd2:    chr1_d = shift_next_c;
          default: prg_d  = shift_next_c;
        endcase
      end else begin
        shift_d = shift_next_c;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      m2_sync_q     <= '0;
      m2_prev_q     <= 1'b0;
      snap_sel_q    <= 2'b00;
      snap_d7_q     <= 1'b0;
      snap_d0_q     <= 1'b0;
      snap_rw_q     <= 1'b1;
      snap_rom_ce_q <= 1'b1;
      shift_q       <= SHIFT_EMPTY;
      ctrl_q        <= CTRL_RESET;
      chr0_q        <= 5'h00;
      chr1_q        <= 5'h00;
      prg_q         <= 5'h00;
      wr_last_q     <= 1'b0;
    end else begin
      m2_sync_q     <= m2_sync_d;
      m2_prev_q     <= m2_prev_d;
      snap_sel_q    <= snap_sel_d;
      snap_d7_q     <= snap_d7_d;
      snap_d0_q     <= snap_d0_d;
      snap_rw_q     <= snap_rw_d;
      snap_rom_ce_q <= snap_rom_ce_d;
      shift_q       <= shift_d;
      ctrl_q        <= ctrl_d;
      chr0_q        <= chr0_d;
      chr1_q        <= chr1_d;
      prg_q         <= prg_d;
      wr_last_q     <= wr_last_d;
    end
  end

  // Bank selection; banks are built 5 bits wide and truncated to the populated range
  always_comb begin
    prg_bank_c = 5'h00;
    chr_bank_c = 5'h00;
    unique case (ctrl_q[3:2])
      2'd0, 2'd1: prg_bank_c = {1'b0, prg_q[3:1], CPU_ADDR[14]};
      2'd2:       prg_bank_c = CPU_ADDR[14] ? {1'b0, prg_q[3:0]} : 5'h00;
      default:    prg_bank_c = CPU_ADDR[14] ? 5'h1F : {1'b0, prg_q[3:0]};
    endcase
    if (ctrl_q[4]) begin
      chr_bank_c = PPU_ADDR[12] ? chr1_q : chr0_q;
    end else begin
      chr_bank_c = {chr0_q[4:1], PPU_ADDR[12]};
    end
    unique case (ctrl_q[1:0])
      2'd0:    CIRAM_A10 = 1'b0;
      2'd1:    CIRAM_A10 = 1'b1;
      2'd2:    CIRAM_A10 = PPU_ADDR[10];
      default: CIRAM_A10 = PPU_ADDR[11];
    endcase
  end

  assign PRG_ADDR = {prg_bank_c[PB-1:0], CPU_ADDR[13:0]};
  assign CHR_ADDR = {chr_bank_c[CB-1:0], PPU_ADDR[11:0]};
  assign CIRAM_CE = ~PPU_ADDR[13];

`ifdef MMC1_PRG_RAM_EN
  assign PRG_RAM_CE = ~(m2_s_c & ROM_CE & (CPU_ADDR[14:13] == 2'b11) & ~prg_q[4]);
  assign unused_c   = ^{CPU_DATA_IN[6:1], prg_bank_c, chr_bank_c};
`else
  assign PRG_RAM_CE = 1'b1;
  assign unused_c   = ^{CPU_DATA_IN[6:1], prg_q[4], prg_bank_c, chr_bank_c};
`endif

endmodule

// File: tb/tb_mmc1_mapper.sv
// Directed bench for mmc1_mapper: serial loads, write filter, mapping modes, reset and PRG-RAM enable.
// Build with MMC1_PRG_RAM_EN defined to exercise the PRG-RAM chip-enable expectations.
module tb_mmc1_mapper;

  logic        CLK;
  logic        RST_N;
  logic        M2;
  logic [14:0] CPU_ADDR;
  logic [7:0]  CPU_DATA_IN;
  logic        CPU_RW;
  logic        ROM_CE;
  logic [13:0] PPU_ADDR;
  logic [17:0] PRG_ADDR;
  logic [16:0] CHR_ADDR;
  logic        CIRAM_A10;
  logic        CIRAM_CE;
  logic        PRG_RAM_CE;

  int errors = 0;
  int checks = 0;

  mmc1_mapper #(
    .PRG_ADDR_W (18),
    .CHR_ADDR_W (17),
    .SYNC_STAGES(2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .M2         (M2),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_DATA_IN(CPU_DATA_IN),
    .CPU_RW     (CPU_RW),
    .ROM_CE     (ROM_CE),
    .PPU_ADDR   (PPU_ADDR),
    .PRG_ADDR   (PRG_ADDR),
    .CHR_ADDR   (CHR_ADDR),
    .CIRAM_A10  (CIRAM_A10),
    .CIRAM_CE   (CIRAM_CE),
    .PRG_RAM_CE (PRG_RAM_CE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One M2 cycle: phase high for 6 CLKs, low for 6 CLKs
  task automatic bus(input logic [14:0] a, input logic [7:0] d, input logic rw, input logic ce);
    @(posedge CLK); #1;
    CPU_ADDR = a; CPU_DATA_IN = d; CPU_RW = rw; ROM_CE = ce; M2 = 1'b1;
    repeat (6) @(posedge CLK);
    #1 M2 = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
  endtask

  // ROM write followed by an idle read cycle so the next write is accepted
  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    bus(a, d, 1'b0, 1'b0);
    bus(15'h0000, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic wr5(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]});
  endtask

  task automatic chk_prg(input string tag, input logic [14:0] a, input logic [17:0] exp);
    CPU_ADDR = a; #1;
    check(tag, 32'(PRG_ADDR), 32'(exp));
  endtask

  task automatic chk_chr(input string tag, input logic [13:0] a, input logic [16:0] exp, input logic a10);
    PPU_ADDR = a; #1;
    check(tag, 32'(CHR_ADDR), 32'(exp));
    check({tag, "_a10"}, 32'(CIRAM_A10), 32'(a10));
  endtask

  task automatic chk_ram(input string tag, input logic exp);
    @(posedge CLK); #1;
    CPU_ADDR = 15'h6000; CPU_RW = 1'b1; ROM_CE = 1'b1; M2 = 1'b1;
    repeat (4) @(posedge CLK);
    #1 check(tag, 32'(PRG_RAM_CE), 32'(exp));
    M2 = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; M2 = 1'b0; CPU_ADDR = '0; CPU_DATA_IN = '0;
    CPU_RW = 1'b1; ROM_CE = 1'b1; PPU_ADDR = '0;
    repeat (4) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Reset state: PRG mode 3, 8K CHR bank 0, one-screen mirroring
    chk_prg("rst_c000", 15'h4000, 18'h3C000);
    chk_prg("rst_c123", 15'h4123, 18'h3C123);
    chk_prg("rst_8000", 15'h0000, 18'h00000);
    chk_chr("rst_chr", 14'h1400, 17'h01400, 1'b0);
    PPU_ADDR = 14'h2000; #1 check("ciram_ce_nt", 32'(CIRAM_CE), 32'd0);
    PPU_ADDR = 14'h1000; #1 check("ciram_ce_pt", 32'(CIRAM_CE), 32'd1);

    // PRG=3 via five serial writes; no commit after the 4th
    for (int i = 0; i < 4; i++) wr(15'h6000, (i < 2) ? 8'h01 : 8'h00);
    chk_prg("prg_4bits", 15'h0000, 18'h00000);
    wr(15'h6000, 8'h00);
    chk_prg("prg3_8000", 15'h0000, 18'h0C000);
    chk_prg("prg3_c000", 15'h4000, 18'h3C000);

    // Two bits, abort with D7, then CHR0=2
    wr(15'h2000, 8'h01);
    wr(15'h2000, 8'h01);
    wr(15'h2000, 8'h80);
    wr5(15'h2000, 5'b00010);
    chk_chr("chr0_lo", 14'h0123, 17'h02123, 1'b0);
    chk_chr("chr0_hi", 14'h1123, 17'h03123, 1'b0);
    chk_prg("ctrl_kept", 15'h4000, 18'h3C000);

    // RMW pair accepted once; out-of-ROM write ignored by the shifter
    wr(15'h6000, 8'h80);
    bus(15'h6000, 8'h01, 1'b0, 1'b0);
    bus(15'h6000, 8'h00, 1'b0, 1'b0);
    bus(15'h0000, 8'h00, 1'b1, 1'b1);
    wr(15'h6000, 8'h00);
    wr(15'h6000, 8'h01);
    bus(15'h6000, 8'h01, 1'b0, 1'b1);
    wr(15'h6000, 8'h00);
    chk_prg("rmw_4bits", 15'h0000, 18'h0C000);
    wr(15'h6000, 8'h00);
    chk_prg("rmw_prg5", 15'h0000, 18'h14000);

    // CONTROL=$12, CHR1=5: 4K CHR, vertical mirroring, 32K PRG
    wr5(15'h0000, 5'b10010);
    wr5(15'h4000, 5'b00101);
    chk_chr("chr1_4k", 14'h1400, 17'h05400, 1'b1);
    chk_chr("chr0_4k", 14'h0400, 17'h02400, 1'b1);
    chk_chr("vert_a10", 14'h1000, 17'h05000, 1'b0);
    chk_prg("m32k_lo", 15'h0000, 18'h10000);
    chk_prg("m32k_hi", 15'h4000, 18'h14000);

    // CONTROL=$0B: PRG mode 2, horizontal mirroring
    wr5(15'h0000, 5'b01011);
    chk_prg("m2_8000", 15'h0000, 18'h00000);
    chk_prg("m2_c000", 15'h4000, 18'h14000);
    chk_chr("horz_1", 14'h0800, 17'h02800, 1'b1);
    chk_chr("horz_0", 14'h0400, 17'h02400, 1'b0);

    // Reset mid-sequence drops partial bits and restores registers
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h01);
    @(posedge CLK); #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    chk_prg("rst2_c000", 15'h4000, 18'h3C000);
    chk_prg("rst2_8000", 15'h0000, 18'h00000);
    chk_chr("rst2_chr", 14'h0800, 17'h00800, 1'b0);
    wr5(15'h6000, 5'b00001);
    chk_prg("rst2_prg1", 15'h0000, 18'h04000);

    // PRG-RAM chip enable
`ifdef MMC1_PRG_RAM_EN
    chk_ram("ram_en", 1'b0);
`else
    chk_ram("ram_tied", 1'b1);
`endif
    wr5(15'h6000, 5'b10000);
    chk_ram("ram_dis", 1'b1);
    chk_prg("prg10_8000", 15'h0000, 18'h00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
